// File: rtl/fir_sample_feeder.sv
// Sample feeder for the 8-tap FIR: 16-entry CPU FIFO drained one sample per
// programmable period (never closer than 4 cycles) as a sample_out/sample_strobe pair.
module fir_sample_feeder #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 5,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div,
  input  logic [CNT_W-1:0]  low_thresh,
  input  logic              clr_flags,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_strobe,
  output logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              overflow,
  output logic              underrun,
  output logic              low_irq
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DIV_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              strobe_q, strobe_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;
  logic              low_irq_q, low_irq_d;

  logic [DIV_W-1:0]  period;
  logic [DIV_W-1:0]  period_m1;
  logic              tick;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push;
  logic              drop;

  always_comb begin
    period    = (div < DIV_W'(4)) ? DIV_W'(4) : div;
    period_m1 = period - DIV_W'(1);
    // >= rather than == so a smaller div mid-period fires at once instead of wrapping
    tick      = enable && (tick_cnt_q >= period_m1);
    empty     = (count_q == '0);
    full      = (count_q == CNT_W'(DEPTH));
    pop       = tick && !empty;
    push      = wr_en && (!full || pop);
    drop      = wr_en && full && !pop;

    tick_cnt_d = tick_cnt_q + DIV_W'(1);
    if (!enable || tick) tick_cnt_d = '0;

    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
    sample_d   = pop ? mem_q[rd_ptr_q] : sample_q;
    strobe_d   = pop;
    // a fresh event outranks a same-cycle clear
    overflow_d = drop | (overflow_q & ~clr_flags);
    underrun_d = (tick && empty) | (underrun_q & ~clr_flags);
    low_irq_d  = enable && (count_q <= low_thresh);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tick_cnt_q <= '0;
      sample_q   <= '0;
      strobe_q   <= 1'b0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      low_irq_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tick_cnt_q <= tick_cnt_d;
      sample_q   <= sample_d;
      strobe_q   <= strobe_d;
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
      low_irq_q  <= low_irq_d;
    end
  end

  assign sample_out    = sample_q;
  assign sample_strobe = strobe_q;
  assign fifo_count    = count_q;
  assign fifo_full     = (count_q == CNT_W'(DEPTH));
  assign fifo_empty    = (count_q == '0);
  assign overflow      = overflow_q;
  assign underrun      = underrun_q;
  assign low_irq       = low_irq_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench for fir_sample_feeder: a fill/overflow vector table plus
// hand-written period, wrap, low-water and reset sequences.
module tb_fir_sample_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        enable;
  logic [15:0] div;
  logic [4:0]  low_thresh;
  logic        clr_flags;
  logic [15:0] sample_out;
  logic        sample_strobe;
  logic [4:0]  fifo_count;
  logic        fifo_full;
  logic        fifo_empty;
  logic        overflow;
  logic        underrun;
  logic        low_irq;

  int passed = 0;
  int total  = 0;

  fir_sample_feeder dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .enable(enable), .div(div), .low_thresh(low_thresh), .clr_flags(clr_flags),
    .sample_out(sample_out), .sample_strobe(sample_strobe), .fifo_count(fifo_count),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .overflow(overflow),
    .underrun(underrun), .low_irq(low_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [15:0] wr_data;
    logic        clr;
    logic [4:0]  exp_count;
    logic        exp_full;
    logic        exp_empty;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[20];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_strobe(input int lim, input string name, output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!sample_strobe && waited < lim);
    total++;
    if (sample_strobe) passed++;
    else $display("FAIL %s: no strobe within %0d cycles, strobe required", name, waited);
  endtask

  task automatic push_word(input logic [15:0] d);
    wr_en = 1'b1;
    wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  initial begin
    int w;
    int nstb;

    reset = 1'b0; wr_en = 1'b0; wr_data = '0; enable = 1'b0;
    div = 16'd10; low_thresh = 5'd0; clr_flags = 1'b0;

    for (int i = 0; i < 17; i++)
      vecs[i] = '{1'b1, 16'(i + 1), 1'b0, 5'((i < 16) ? i + 1 : 16), (i >= 15), 1'b0, (i == 16)};
    vecs[17] = '{1'b1, 16'hDEAD, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1};
    vecs[18] = '{1'b0, 16'h0000, 1'b1, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 16'h0000, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};

    // reset values and idle
    do_reset();
    chk("rst_sample_out", sample_out, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_low_irq", low_irq, 0);
    nstb = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (sample_strobe) nstb++;
    end
    chk("idle_no_strobe", nstb, 0);

    // five samples, div=10
    for (int i = 1; i <= 5; i++) push_word(16'(i));
    chk("p10_count5", fifo_count, 5);
    enable = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_strobe(30, "p10_strobe", w);
      chk("p10_spacing", w, 10);
      chk("p10_data", sample_out, i);
    end
    chk("p10_count0", fifo_count, 0);
    for (int i = 0; i < 9; i++) step();
    chk("p10_underrun_early", underrun, 0);
    step();
    chk("p10_underrun_set", underrun, 1);
    chk("p10_underrun_nostrobe", sample_strobe, 0);
    chk("p10_sample_hold", sample_out, 16'h0005);
    enable = 1'b0;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_underrun", underrun, 0);

    // div 0 then 2: both clamp to 4
    for (int i = 0; i < 8; i++) push_word(16'h0010 + 16'(i));
    div = 16'd0;
    enable = 1'b1;
    wait_strobe(10, "p4_first", w);
    chk("p4_first_latency", w, 4);
    chk("p4_data0", sample_out, 16'h0010);
    for (int i = 1; i < 8; i++) begin
      if (i == 4) div = 16'd2;
      step();
      chk("p4_strobe_width", sample_strobe, 0);
      wait_strobe(10, "p4_strobe", w);
      chk("p4_spacing", w, 3);
      chk("p4_data", sample_out, 16'h0010 + 16'(i));
    end
    enable = 1'b0;

    // table: fill past full with enable low, overflow and clear priority
    do_reset();
    for (int i = 0; i < 20; i++) begin
      wr_en = vecs[i].wr_en;
      wr_data = vecs[i].wr_data;
      clr_flags = vecs[i].clr;
      step();
      chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
      chk($sformatf("vec%0d_full", i), fifo_full, vecs[i].exp_full);
      chk($sformatf("vec%0d_empty", i), fifo_empty, vecs[i].exp_empty);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end
    wr_en = 1'b0;
    clr_flags = 1'b0;

    // full FIFO: push coinciding with tick pop, across pointer wrap
    div = 16'd4;
    enable = 1'b1;
    step(); step(); step();
    wr_en = 1'b1;
    wr_data = 16'h0100;
    step();
    wr_en = 1'b0;
    chk("wrap_strobe", sample_strobe, 1);
    chk("wrap_data1", sample_out, 16'h0001);
    chk("wrap_count16", fifo_count, 16);
    chk("wrap_no_ovf", overflow, 0);
    for (int i = 2; i <= 17; i++) begin
      wait_strobe(10, "wrap_strobe", w);
      chk("wrap_spacing", w, 4);
      chk("wrap_data", sample_out, (i == 17) ? 16'h0100 : 16'(i));
    end
    chk("wrap_empty", fifo_empty, 1);
    enable = 1'b0;

    // low-water interrupt then reset mid-run
    do_reset();
    low_thresh = 5'd2;
    div = 16'd10;
    for (int i = 0; i < 4; i++) push_word(16'h0021 + 16'(i));
    chk("low_irq_disabled", low_irq, 0);
    enable = 1'b1;
    wait_strobe(20, "low_s1", w);
    chk("low_count3", fifo_count, 3);
    chk("low_irq_at3", low_irq, 0);
    wait_strobe(20, "low_s2", w);
    chk("low_count2", fifo_count, 2);
    chk("low_irq_lag", low_irq, 0);
    step();
    chk("low_irq_rise", low_irq, 1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_count", fifo_count, 0);
    chk("mid_rst_low_irq", low_irq, 0);
    chk("mid_rst_strobe", sample_strobe, 0);
    chk("mid_rst_empty", fifo_empty, 1);
    @(posedge clk);
    #1 reset = 1'b1;
    nstb = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (sample_strobe) nstb++;
    end
    chk("post_rst_no_strobe", nstb, 0);
    chk("post_rst_underrun", underrun, 1);
    push_word(16'h0055);
    wait_strobe(25, "post_rst_push", w);
    chk("post_rst_data", sample_out, 16'h0055);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
